// File: rtl/dai_pkg.sv
// Shared constants and state encoding for the DAI receiver and the downstream cacher.
package dai_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } dai_state_e;

    localparam int BW_BITCNT = 6;
    localparam logic [BW_BITCNT-1:0] BITCNT_SAT = 6'd63;

    localparam int DAI_BW_SLOT = 24;
    localparam int DAI_BW_OUT  = 9;

    function automatic logic [BW_BITCNT-1:0] bitcnt_inc(input logic [BW_BITCNT-1:0] cnt);
        return (cnt == BITCNT_SAT) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dai_receiver_if.sv
// Sample-pair handoff from the DAI receiver (master) to the capture stage (slave).
interface dai_receiver_if
    import dai_pkg::*;
#(
    parameter int BW_OUT = DAI_BW_OUT
);
    logic [BW_OUT-1:0] sample_l;
    logic [BW_OUT-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ack;
    logic              overrun;
    logic              short_slot;

    modport master (
        output sample_l, sample_r, sample_valid, overrun, short_slot,
        input  sample_ack
    );

    modport slave (
        input  sample_l, sample_r, sample_valid, overrun, short_slot,
        output sample_ack
    );
endinterface

// File: rtl/dai_sync_edge.sv
// Synchronizes BCK/LRCK/SData into the PLL clock domain and flags BCK rising edges.
module dai_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bck_i,
    input  logic lrck_i,
    input  logic sdata_i,
    output logic bck_rise_o,
    output logic lrck_o,
    output logic sdata_o
);
    // bit 2 = BCK, bit 1 = LRCK, bit 0 = SData
    logic [2:0] sync_q [SYNC_STAGES];
    logic       bck_hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            bck_hist_q <= 1'b0;
        end else begin
            sync_q[0] <= {bck_i, lrck_i, sdata_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            bck_hist_q <= sync_q[SYNC_STAGES-1][2];
        end
    end

    assign bck_rise_o = sync_q[SYNC_STAGES-1][2] & ~bck_hist_q;
    assign lrck_o     = sync_q[SYNC_STAGES-1][1];
    assign sdata_o    = sync_q[SYNC_STAGES-1][0];

endmodule

// File: rtl/dai_receiver.sv
// DAI front end: deserializes one stereo frame per LRCK period into a truncated L/R pair.
// DAI_LJ_FORMAT_EN selects left-justified framing (no bit delay); default is I2S.
//   state     | meaning
//   WAIT_SYNC | discard input until the first LRCK 1->0 boundary
//   LEFT      | collecting the left slot
//   RIGHT     | collecting the right slot
module dai_receiver
    import dai_pkg::*;
#(
    parameter int BW_SLOT     = DAI_BW_SLOT,
    parameter int BW_OUT      = DAI_BW_OUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           bck_i,
    input  logic           lrck_i,
    input  logic           sdata_i,
    dai_receiver_if.master out_if
);
    localparam logic [BW_BITCNT-1:0] SLOT_LEN = BW_BITCNT'(BW_SLOT);
    localparam logic [BW_BITCNT-1:0] MIN_BITS = BW_BITCNT'(BW_OUT);

    logic bck_rise, lrck_s, sdata_s;

    dai_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bck_i      (bck_i),
        .lrck_i     (lrck_i),
        .sdata_i    (sdata_i),
        .bck_rise_o (bck_rise),
        .lrck_o     (lrck_s),
        .sdata_o    (sdata_s)
    );

    dai_state_e           state_q, state_d;
    logic                 lrck_prev_q, lrck_prev_d;
    logic [BW_BITCNT-1:0] bitcnt_q, bitcnt_d;
    logic [BW_BITCNT-1:0] nacc_q, nacc_d;
    logic [BW_SLOT-1:0]   shreg_q, shreg_d;
    logic [BW_OUT-1:0]    left_q, left_d;
    logic                 left_short_q, left_short_d;
    logic [BW_OUT-1:0]    sample_l_q, sample_l_d;
    logic [BW_OUT-1:0]    sample_r_q, sample_r_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 short_q, short_d;

    logic                 boundary, bnd_rise, bnd_fall;
    logic                 accept;
    logic                 latch_left, latch_right, emit;
    logic [BW_BITCNT-1:0] pad;
    logic [BW_OUT-1:0]    slot_top;
    logic                 short_now;

    assign boundary = bck_rise & (lrck_s != lrck_prev_q);
    assign bnd_rise = boundary & lrck_s;
    assign bnd_fall = boundary & ~lrck_s;

    // Slot value as seen at its end: left-justify the accepted bits, keep the MSBs.
    assign pad       = SLOT_LEN - nacc_q;
    assign slot_top  = BW_OUT'((shreg_q << pad) >> (BW_SLOT - BW_OUT));
    assign short_now = nacc_q < MIN_BITS;

    always_comb begin
        lrck_prev_d = lrck_prev_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        nacc_d      = nacc_q;
        accept      = 1'b0;
        if (bck_rise) begin
            lrck_prev_d = lrck_s;
            bitcnt_d    = boundary ? '0 : bitcnt_inc(bitcnt_q);
            shreg_d     = boundary ? '0 : shreg_q;
            nacc_d      = boundary ? '0 : nacc_q;
`ifdef DAI_LJ_FORMAT_EN
            accept = bitcnt_d < SLOT_LEN;
`else
            accept = (bitcnt_d != '0) && (bitcnt_d <= SLOT_LEN);
`endif
            if (accept) begin
                shreg_d = {shreg_d[BW_SLOT-2:0], sdata_s};
                nacc_d  = nacc_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= WAIT_SYNC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_SYNC: if (bnd_fall) state_d = LEFT;
            LEFT:      if (bnd_rise) state_d = RIGHT;
            RIGHT:     if (bnd_fall) state_d = LEFT;
            default:   state_d = WAIT_SYNC;
        endcase
    end

    always_comb begin
        latch_left  = (state_q == LEFT)  && bnd_rise;
        latch_right = (state_q == RIGHT) && bnd_fall;
    end

    always_comb begin
        left_d       = left_q;
        left_short_d = left_short_q;
        sample_l_d   = sample_l_q;
        sample_r_d   = sample_r_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        short_d      = short_q;
        emit         = 1'b0;
        if (latch_left) begin
            left_d       = slot_top;
            left_short_d = short_now;
            if (short_now) short_d = 1'b1;
        end
        if (latch_right) begin
            if (short_now) short_d = 1'b1;
            emit = !short_now && !left_short_q;
        end
        if (valid_q && out_if.sample_ack) valid_d = 1'b0;
        // An ack in the emit cycle retires the old pair, so it is not an overrun.
        if (emit) begin
            sample_l_d = left_q;
            sample_r_d = slot_top;
            valid_d    = 1'b1;
            if (valid_q && !out_if.sample_ack) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lrck_prev_q  <= 1'b0;
            bitcnt_q     <= '0;
            nacc_q       <= '0;
            shreg_q      <= '0;
            left_q       <= '0;
            left_short_q <= 1'b0;
            sample_l_q   <= '0;
            sample_r_q   <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            lrck_prev_q  <= lrck_prev_d;
            bitcnt_q     <= bitcnt_d;
            nacc_q       <= nacc_d;
            shreg_q      <= shreg_d;
            left_q       <= left_d;
            left_short_q <= left_short_d;
            sample_l_q   <= sample_l_d;
            sample_r_q   <= sample_r_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            short_q      <= short_d;
        end
    end

    assign out_if.sample_l     = sample_l_q;
    assign out_if.sample_r     = sample_r_q;
    assign out_if.sample_valid = valid_q;
    assign out_if.overrun      = overrun_q;
    assign out_if.short_slot   = short_q;

endmodule

// File: tb/tb_dai_receiver.sv
// Directed bench for dai_receiver: serial frames driven at 8 clocks per BCK, outputs checked against hand values.
module tb_dai_receiver;

`ifdef DAI_LJ_FORMAT_EN
    localparam int         DLY       = 0;
    localparam logic [8:0] EXP_NODLY = 9'h0FF;
`else
    localparam int         DLY       = 1;
    localparam logic [8:0] EXP_NODLY = 9'h1FF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bck = 1'b0, lrck = 1'b0, sdata = 1'b0;
    int   n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    dai_receiver_if #(.BW_OUT(9)) dif ();

    dai_receiver #(.BW_SLOT(24), .BW_OUT(9), .SYNC_STAGES(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bck_i   (bck),
        .lrck_i  (lrck),
        .sdata_i (sdata),
        .out_if  (dif)
    );

    // One BCK period: low for 4 clocks, high for 4; optional ack lands on the sampling edge of this rise.
    task automatic bck_bit(input logic lr, input logic d, input logic ack_rise);
        @(negedge clk);
        bck = 1'b0; lrck = lr; sdata = d;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        repeat (2) @(negedge clk);
        if (ack_rise) dif.sample_ack = 1'b1;
        @(negedge clk);
        dif.sample_ack = 1'b0;
    endtask

    task automatic send_bits(input logic lr, input logic [23:0] val, input int dly,
                             input int from, input int to);
        int   k;
        logic d;
        for (int i = from; i < to; i++) begin
            k = i - dly;
            d = (k >= 0 && k < 24) ? val[23-k] : 1'b0;
            bck_bit(lr, d, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n, input int dly);
        send_bits(1'b0, l, dly, 0, n);
        send_bits(1'b1, r, dly, 0, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bck = 1'b0; lrck = 1'b0; sdata = 1'b0; dif.sample_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dif.sample_l !== 9'h000) begin n_fail++; $display("FAIL reset_L: got %h want 000", dif.sample_l); end
        n_cmp++; if (dif.sample_r !== 9'h000) begin n_fail++; $display("FAIL reset_R: got %h want 000", dif.sample_r); end
        n_cmp++; if (dif.sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dif.sample_valid); end
        n_cmp++; if (dif.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", dif.overrun); end
        n_cmp++; if (dif.short_slot !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b want 0", dif.short_slot); end
    endtask

    task automatic test_basic();
        do_reset();
        send_frame(24'h7FFFFF, 24'h800000, 32, DLY);
        send_frame(24'h7FFFFF, 24'h800000, 32, DLY);
        // Emitting boundary: valid must appear exactly at E+1.
        @(negedge clk);
        bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (dif.sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_E: got %b want 0", dif.sample_valid); end
        @(posedge clk); #1;
        n_cmp++; if (dif.sample_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_E1: got %b want 1", dif.sample_valid); end
        n_cmp++; if (dif.sample_l !== 9'h0FF) begin n_fail++; $display("FAIL basic_L: got %h want 0ff", dif.sample_l); end
        n_cmp++; if (dif.sample_r !== 9'h100) begin n_fail++; $display("FAIL basic_R: got %h want 100", dif.sample_r); end
        @(negedge clk);
    endtask

    task automatic test_ack();
        do_reset();
        send_frame(24'h0, 24'h0, 32, DLY);
        send_frame(24'h123456, 24'hFEDCBA, 32, DLY);
        send_bits(1'b0, 24'h0, DLY, 0, 1);
        n_cmp++; if (dif.sample_valid !== 1'b1) begin n_fail++; $display("FAIL ack_valid_set: got %b want 1", dif.sample_valid); end
        n_cmp++; if (dif.sample_l !== 9'h024) begin n_fail++; $display("FAIL ack_L: got %h want 024", dif.sample_l); end
        n_cmp++; if (dif.sample_r !== 9'h1FD) begin n_fail++; $display("FAIL ack_R: got %h want 1fd", dif.sample_r); end
        dif.sample_ack = 1'b1;
        @(negedge clk);
        dif.sample_ack = 1'b0;
        n_cmp++; if (dif.sample_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid_clr: got %b want 0", dif.sample_valid); end
        // A stray ack with nothing pending changes nothing.
        dif.sample_ack = 1'b1;
        repeat (2) @(negedge clk);
        dif.sample_ack = 1'b0;
        n_cmp++; if (dif.sample_valid !== 1'b0 || dif.overrun !== 1'b0)
            begin n_fail++; $display("FAIL ack_idle: got valid %b overrun %b want 0 0", dif.sample_valid, dif.overrun); end
        n_cmp++; if (dif.sample_l !== 9'h024) begin n_fail++; $display("FAIL ack_idle_L: got %h want 024", dif.sample_l); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(24'h0, 24'h0, 32, DLY);
        send_frame(24'h123456, 24'hFEDCBA, 32, DLY);
        send_bits(1'b0, 24'h7FFFFF, DLY, 0, 1);
        n_cmp++; if (dif.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %b want 0", dif.overrun); end
        send_bits(1'b0, 24'h7FFFFF, DLY, 1, 32);
        send_bits(1'b1, 24'h800000, DLY, 0, 32);
        send_bits(1'b0, 24'h0, DLY, 0, 1);
        n_cmp++; if (dif.sample_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", dif.sample_valid); end
        n_cmp++; if (dif.sample_l !== 9'h0FF) begin n_fail++; $display("FAIL ovr_L: got %h want 0ff", dif.sample_l); end
        n_cmp++; if (dif.sample_r !== 9'h100) begin n_fail++; $display("FAIL ovr_R: got %h want 100", dif.sample_r); end
        n_cmp++; if (dif.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", dif.overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(24'h0, 24'h0, 32, DLY);
        send_frame(24'h123456, 24'hFEDCBA, 32, DLY);
        send_bits(1'b0, 24'h7FFFFF, DLY, 0, 1);
        n_cmp++; if (dif.sample_l !== 9'h024) begin n_fail++; $display("FAIL b2b_first_L: got %h want 024", dif.sample_l); end
        send_bits(1'b0, 24'h7FFFFF, DLY, 1, 32);
        send_bits(1'b1, 24'h800000, DLY, 0, 32);
        bck_bit(1'b0, 1'b0, 1'b1);
        n_cmp++; if (dif.sample_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", dif.sample_valid); end
        n_cmp++; if (dif.sample_l !== 9'h0FF) begin n_fail++; $display("FAIL b2b_L: got %h want 0ff", dif.sample_l); end
        n_cmp++; if (dif.sample_r !== 9'h100) begin n_fail++; $display("FAIL b2b_R: got %h want 100", dif.sample_r); end
        n_cmp++; if (dif.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", dif.overrun); end
    endtask

    task automatic test_short_slot();
        do_reset();
        send_frame(24'h0, 24'h0, 32, DLY);
        send_frame(24'hFFFFFF, 24'hFFFFFF, 6, DLY);
        send_bits(1'b0, 24'h123456, DLY, 0, 1);
        n_cmp++; if (dif.short_slot !== 1'b1) begin n_fail++; $display("FAIL short_flag: got %b want 1", dif.short_slot); end
        n_cmp++; if (dif.sample_valid !== 1'b0) begin n_fail++; $display("FAIL short_novalid: got %b want 0", dif.sample_valid); end
        send_bits(1'b0, 24'h123456, DLY, 1, 32);
        send_bits(1'b1, 24'hFEDCBA, DLY, 0, 32);
        send_bits(1'b0, 24'h0, DLY, 0, 1);
        n_cmp++; if (dif.sample_valid !== 1'b1) begin n_fail++; $display("FAIL short_resume_valid: got %b want 1", dif.sample_valid); end
        n_cmp++; if (dif.sample_l !== 9'h024) begin n_fail++; $display("FAIL short_resume_L: got %h want 024", dif.sample_l); end
        n_cmp++; if (dif.sample_r !== 9'h1FD) begin n_fail++; $display("FAIL short_resume_R: got %h want 1fd", dif.sample_r); end
        n_cmp++; if (dif.short_slot !== 1'b1) begin n_fail++; $display("FAIL short_sticky: got %b want 1", dif.short_slot); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(24'h0, 24'h0, 32, DLY);
        send_frame(24'h123456, 24'hFEDCBA, 32, DLY);
        send_bits(1'b0, 24'h7FFFFF, DLY, 0, 32);
        send_bits(1'b1, 24'h800000, DLY, 0, 16);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dif.sample_l !== 9'h000 || dif.sample_r !== 9'h000)
            begin n_fail++; $display("FAIL rmid_LR: got %h %h want 000 000", dif.sample_l, dif.sample_r); end
        n_cmp++; if (dif.sample_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", dif.sample_valid); end
        n_cmp++; if (dif.overrun !== 1'b0 || dif.short_slot !== 1'b0)
            begin n_fail++; $display("FAIL rmid_flags: got %b %b want 0 0", dif.overrun, dif.short_slot); end
        @(negedge clk);
        rst = 1'b0;
        send_bits(1'b1, 24'h800000, DLY, 16, 32);
        send_frame(24'h7FFFFF, 24'h800000, 32, DLY);
        n_cmp++; if (dif.sample_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_early: got %b want 0", dif.sample_valid); end
        send_bits(1'b0, 24'h0, DLY, 0, 1);
        n_cmp++; if (dif.sample_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_after: got %b want 1", dif.sample_valid); end
        n_cmp++; if (dif.sample_l !== 9'h0FF) begin n_fail++; $display("FAIL rmid_L: got %h want 0ff", dif.sample_l); end
        n_cmp++; if (dif.sample_r !== 9'h100) begin n_fail++; $display("FAIL rmid_R: got %h want 100", dif.sample_r); end
    endtask

    // Data sent with no bit delay: LJ captures it aligned, I2S sees it shifted by one.
    task automatic test_format();
        do_reset();
        send_frame(24'h0, 24'h0, 32, 0);
        send_frame(24'h7FFFFF, 24'h000000, 32, 0);
        send_bits(1'b0, 24'h0, 0, 0, 1);
        n_cmp++; if (dif.sample_valid !== 1'b1) begin n_fail++; $display("FAIL fmt_valid: got %b want 1", dif.sample_valid); end
        n_cmp++; if (dif.sample_l !== EXP_NODLY) begin n_fail++; $display("FAIL fmt_L: got %h want %h", dif.sample_l, EXP_NODLY); end
        n_cmp++; if (dif.sample_r !== 9'h000) begin n_fail++; $display("FAIL fmt_R: got %h want 000", dif.sample_r); end
    endtask

    initial begin
        dif.sample_ack = 1'b0;
        test_reset();
        test_basic();
        test_ack();
        test_overrun();
        test_back_to_back();
        test_short_slot();
        test_reset_mid();
        test_format();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
